// File: rtl/threefish_round_sequencer.sv
// Threefish round sequencer: walks one block through subkey injection, MIX pairs
// and word permutation, and emits the operand selects and unit strobes.
module threefish_round_sequencer #(
  parameter int ROUNDS       = 80,
  parameter int MIXES        = 8,
  parameter int INJECT_EVERY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       hold_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] word_o,
  output logic [6:0] round_o,
  output logic [4:0] subkey_o,
  output logic       mix_en_o,
  output logic       perm_en_o,
  output logic       inject_en_o,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INJECT = 3'd1,
    MIX    = 3'd2,
    PERM   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_WORD   = 4'(2 * (MIXES - 1));
  localparam logic [6:0] LAST_ROUND  = 7'(ROUNDS - 1);
  localparam logic [4:0] NUM_SUBKEYS = 5'(ROUNDS / INJECT_EVERY);
  localparam logic [7:0] ROUNDS_W    = 8'(ROUNDS);
  localparam logic [7:0] INJECT_W    = 8'(INJECT_EVERY);

  state_t     state_q, state_d;
  logic [3:0] word_q, word_d;
  logic [6:0] round_q, round_d;
  logic [4:0] subkey_q, subkey_d;
  logic [7:0] round_inc;
  logic       inject_due;
  logic       active;

  assign round_inc  = {1'b0, round_q} + 8'd1;
  assign inject_due = (round_inc % INJECT_W) == 8'd0;
  assign active     = (state_q == INJECT) || (state_q == MIX) || (state_q == PERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      round_q  <= '0;
      subkey_q <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      round_q  <= round_d;
      subkey_q <= subkey_d;
    end
  end

  // A held active step keeps every register as-is so the same step replays on release.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    round_d  = round_q;
    subkey_d = subkey_q;
    if (!(hold_i && active)) begin
      case (state_q)
        IDLE: begin
          if (start_i) state_d = INJECT;
        end
        INJECT: begin
          if (subkey_q == NUM_SUBKEYS) begin
            state_d = DONE;
          end else begin
            state_d  = MIX;
            word_d   = '0;
            subkey_d = subkey_q + 5'd1;
          end
        end
        MIX: begin
          if (word_q == LAST_WORD) begin
            state_d = PERM;
            word_d  = '0;
          end else begin
            word_d = word_q + 4'd2;
          end
        end
        PERM: begin
          // The final permutation still leads to an injection; round stays at the last value.
          round_d = (round_inc >= ROUNDS_W) ? LAST_ROUND : round_inc[6:0];
          state_d = inject_due ? INJECT : MIX;
        end
        DONE: begin
          state_d  = IDLE;
          word_d   = '0;
          round_d  = '0;
          subkey_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_o      = active;
  assign done_o      = (state_q == DONE);
  assign mix_en_o    = (state_q == MIX) && !hold_i;
  assign perm_en_o   = (state_q == PERM) && !hold_i;
  assign inject_en_o = (state_q == INJECT) && !hold_i;
  assign word_o      = word_q;
  assign round_o     = round_q;
  assign subkey_o    = subkey_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_threefish_round_sequencer.sv
// Directed bench for threefish_round_sequencer: full blocks, reset abort, hold,
// held start, and a reduced-parameter instance.
module tb_threefish_round_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic on_b = 1'b0;
  logic start_a, start_b;

  logic       busy_a, done_a, mix_a, perm_a, inj_a;
  logic [3:0] word_a;
  logic [6:0] round_a;
  logic [4:0] sub_a;
  logic [2:0] st_a;
  logic       busy_b, done_b, mix_b, perm_b, inj_b;
  logic [3:0] word_b;
  logic [6:0] round_b;
  logic [4:0] sub_b;
  logic [2:0] st_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_busy, n_mix, n_perm, n_inj;
  logic [19:0] exp_q[$];
  logic        hold_q[$];

  assign start_a = start && !on_b;
  assign start_b = start && on_b;

  always #5 clk = ~clk;

  threefish_round_sequencer dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .hold_i(hold),
    .busy_o(busy_a), .done_o(done_a), .word_o(word_a), .round_o(round_a),
    .subkey_o(sub_a), .mix_en_o(mix_a), .perm_en_o(perm_a), .inject_en_o(inj_a),
    .fsm_state(st_a)
  );

  threefish_round_sequencer #(.ROUNDS(8), .MIXES(4), .INJECT_EVERY(4)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .hold_i(hold),
    .busy_o(busy_b), .done_o(done_b), .word_o(word_b), .round_o(round_b),
    .subkey_o(sub_b), .mix_en_o(mix_b), .perm_en_o(perm_b), .inject_en_o(inj_b),
    .fsm_state(st_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {busy, inject, mix, perm, word, round, subkey}
  function automatic logic [19:0] ent(input logic b, input logic i, input logic m,
                                      input logic p, input int w, input int r, input int s);
    ent = {b, i, m, p, 4'(w), 7'(r), 5'(s)};
  endfunction

  function automatic logic [19:0] obs();
    if (on_b) obs = {busy_b, inj_b, mix_b, perm_b, word_b, round_b, sub_b};
    else      obs = {busy_a, inj_a, mix_a, perm_a, word_a, round_a, sub_a};
  endfunction

  function automatic logic sel_done();
    sel_done = on_b ? done_b : done_a;
  endfunction

  // Expected step sequence built straight from the round structure.
  task automatic gen_model(input int nr, input int nm, input int ie,
                           input int hr, input int hw, input int hl);
    exp_q.delete();
    hold_q.delete();
    for (int r = 0; r < nr; r++) begin
      if (r % ie == 0) begin
        exp_q.push_back(ent(1, 1, 0, 0, 0, r, r / ie));
        hold_q.push_back(1'b0);
      end
      for (int w = 0; w < nm; w++) begin
        if (r == hr && 2 * w == hw) begin
          for (int h = 0; h < hl; h++) begin
            exp_q.push_back(ent(1, 0, 0, 0, 2 * w, r, r / ie + 1));
            hold_q.push_back(1'b1);
          end
        end
        exp_q.push_back(ent(1, 0, 1, 0, 2 * w, r, r / ie + 1));
        hold_q.push_back(1'b0);
      end
      exp_q.push_back(ent(1, 0, 0, 1, 0, r, r / ie + 1));
      hold_q.push_back(1'b0);
    end
    exp_q.push_back(ent(1, 1, 0, 0, 0, nr - 1, nr / ie));
    hold_q.push_back(1'b0);
  endtask

  task automatic tick(input bit keep_start);
    @(posedge clk);
    cyc++;
    #1;
    if (!keep_start) start = 1'b0;
    hold = (hold_q.size() > 0) ? hold_q.pop_front() : 1'b0;
    #1;
  endtask

  // Runs one block against exp_q; abort_e names the step at which rst is pulsed.
  task automatic run_block(input bit keep_start, input logic [19:0] abort_e, input int exp_done);
    logic [19:0] o, e;
    n_busy = 0; n_mix = 0; n_perm = 0; n_inj = 0;
    cyc = 0;
    start = 1'b1;
    while (exp_q.size() > 0) begin
      tick(keep_start);
      o = obs();
      e = exp_q.pop_front();
      check($sformatf("step_c%0d", cyc), 32'(o), 32'(e));
      n_busy += int'(o[19]);
      n_inj  += int'(o[18]);
      n_mix  += int'(o[17]);
      n_perm += int'(o[16]);
      if (e == abort_e) begin
        rst = 1'b1;
        #1;
        check("rst_outs", 32'({obs(), sel_done()}), 32'd0);
        check("rst_state", 32'(st_a), 32'd0);
        exp_q.delete();
        hold_q.delete();
        @(negedge clk);
        tick(1'b0);
        check("rst_no_done", 32'({obs(), sel_done()}), 32'd0);
        rst = 1'b0;
        #2;
        return;
      end
    end
    tick(keep_start);
    check("done_hi", 32'(sel_done()), 32'd1);
    check("done_cyc", 32'(cyc), 32'(exp_done));
    check("done_busy", 32'(obs()), 32'({1'b0, 19'(obs())}));
    tick(keep_start);
    check("done_lo", 32'(sel_done()), 32'd0);
  endtask

  initial begin
    #2;
    check("reset_outs", 32'({obs(), sel_done()}), 32'd0);
    check("reset_state", 32'(st_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Abort mid-MIX at round 5 word 6.
    gen_model(80, 8, 4, -1, 0, 0);
    run_block(1'b0, ent(1, 0, 1, 0, 6, 5, 2), 0);
    @(negedge clk);

    // Full block after abort: restarts from subkey 0 / round 0.
    gen_model(80, 8, 4, -1, 0, 0);
    run_block(1'b0, 20'd0, 742);
    check("busy_cnt", 32'(n_busy), 32'd741);
    check("mix_cnt", 32'(n_mix), 32'd640);
    check("perm_cnt", 32'(n_perm), 32'd80);
    check("inj_cnt", 32'(n_inj), 32'd21);
    check("idle_after", 32'(st_a), 32'd0);
    @(negedge clk);

    // Hold three cycles at round 10 word 8.
    gen_model(80, 8, 4, 10, 8, 3);
    run_block(1'b0, 20'd0, 745);
    check("hold_mix_cnt", 32'(n_mix), 32'd640);
    check("hold_busy_cnt", 32'(n_busy), 32'd744);
    @(negedge clk);

    // Start held high for the whole block: only re-accepted from IDLE.
    gen_model(80, 8, 4, -1, 0, 0);
    run_block(1'b1, 20'd0, 742);
    check("ks_mix_cnt", 32'(n_mix), 32'd640);
    check("ks_inj_cnt", 32'(n_inj), 32'd21);
    check("ks_idle_743", 32'({obs(), sel_done()}), 32'd0);
    tick(1'b0);
    check("ks_restart", 32'(obs()), 32'(ent(1, 1, 0, 0, 0, 0, 0)));
    rst = 1'b1;
    #1;
    rst = 1'b0;
    @(negedge clk);

    // Reduced parameters: 8 rounds, 4 mixes.
    on_b = 1'b1;
    gen_model(8, 4, 4, -1, 0, 0);
    run_block(1'b0, 20'd0, 44);
    check("b_inj_cnt", 32'(n_inj), 32'd3);
    check("b_mix_cnt", 32'(n_mix), 32'd32);
    check("b_perm_cnt", 32'(n_perm), 32'd8);
    on_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
